fifo_byte_packer: RTL and testbench

Read-side consumer stage for the team's synchronous byte FIFO. It drains bytes through the FIFO's `rd_en`/`dout`/`empty` port, which has one cycle of read latency and a registered `dout`. It packs `PACK` consecutive bytes little-endian into one word and presents each word on a valid/ready master stream with a per-byte keep mask. A flush request emits a partially filled word, so no data is stranded in the assembler.

---
 rtl/fifo_byte_packer.sv | 68 ++++++
 tb/tb_fifo_byte_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_packer.sv
// fifo_byte_packer: drains a one-cycle-latency FIFO read port and packs PACK entries
// little-endian into keep-masked words on a valid/ready stream, with flush of partial words.
module fifo_byte_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK = 4,
    parameter int OUT_WIDTH = DATA_WIDTH*PACK
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic [PACK-1:0]      m_keep
);
    localparam int CW = $clog2(PACK+1);
    logic [CW-1:0]        asm_cnt;
    logic [CW-1:0]        land_slot;
    logic [CW:0]          occupancy;
    logic                 rd_pend;
    logic                 flush_req;
    logic                 flush_ready;
    logic                 flush_done;
    logic                 xfer;
    logic [OUT_WIDTH-1:0] asm_data;
    logic [OUT_WIDTH-1:0] word;
    logic [PACK-1:0]      keep;
    always_comb begin
        occupancy = {1'b0, asm_cnt} + {{CW{1'b0}}, rd_pend};
        flush_ready = flush_req && !rd_pend && asm_cnt != '0;
        xfer = (asm_cnt == CW'(PACK) || flush_ready) && (!m_valid || m_ready);
        fifo_rd_en = !rst && !fifo_empty && !flush_req && (occupancy < (CW+1)'(PACK) || xfer);
        flush_done = (flush_ready && xfer) || (asm_cnt == '0 && !rd_pend);
        land_slot = xfer ? '0 : asm_cnt;
        for (int i = 0; i < PACK; i++) begin
            keep[i] = CW'(i) < asm_cnt;
            word[i*DATA_WIDTH +: DATA_WIDTH] = keep[i] ? asm_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_cnt   <= '0;
            rd_pend   <= 1'b0;
            flush_req <= 1'b0;
            asm_data  <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_keep    <= '0;
        end else begin
            rd_pend   <= fifo_rd_en;
            flush_req <= flush_req ? !flush_done : flush;
            asm_cnt   <= xfer ? {{(CW-1){1'b0}}, rd_pend} : asm_cnt + {{(CW-1){1'b0}}, rd_pend};
            for (int i = 0; i < PACK; i++)
                if (rd_pend && land_slot == CW'(i))
                    asm_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
            if (xfer) begin
                m_valid <= 1'b1;
                m_data  <= word;
                m_keep  <= keep;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb_fifo_byte_packer: FIFO read-port model plus scoreboard of expected {keep,data} words.
module tb_fifo_byte_packer;
    logic        clk = 0;
    logic        rst = 1;
    logic        fifo_empty = 1;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout = '0;
    logic        flush = 0;
    logic        m_valid;
    logic        m_ready = 0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;

    int tests_run = 0;
    int tests_failed = 0;
    int rd_count = 0;
    logic [7:0]  fq[$];
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];

    fifo_byte_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_keep(m_keep)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fifo_empty <= 1'b1;
        end else if (fifo_rd_en && fq.size() != 0) begin
            fifo_dout <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) got_q.push_back({m_keep, m_data});
        if (fifo_rd_en) rd_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 300 && got_q.size() < n; i++) tick();
    endtask

    task automatic test_reset();
        logic [35:0] w;
        tick();
        tick();
        push(8'h55);
        @(negedge clk);
        tests_run++;
        if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        tests_run++;
        if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        tests_run++;
        w = {m_keep, m_data};
        if (w !== 36'h0) begin tests_failed++; $display("FAIL reset_data_keep got=%h exp=0", w); end
        tick();
        rst = 0;
        m_ready = 1;
        tick();
        @(negedge clk);
        tests_run++;
        if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_fifo_cleared got=%b exp=0", fifo_rd_en); end
    endtask

    task automatic test_streaming();
        logic [35:0] w, e;
        tick();
        rd_count = 0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        exp_q.push_back({4'hF, 32'h04030201});
        exp_q.push_back({4'hF, 32'h08070605});
        wait_words(2);
        for (int i = 0; i < 2; i++) begin
            w = got_q.size() != 0 ? got_q.pop_front() : 'x;
            e = exp_q.pop_front();
            tests_run++;
            if (w !== e) begin tests_failed++; $display("FAIL stream_word%0d got=%h exp=%h", i, w, e); end
        end
        tests_run++;
        if (rd_count !== 8) begin tests_failed++; $display("FAIL stream_reads got=%0d exp=8", rd_count); end
    endtask

    task automatic test_backpressure();
        logic [35:0] w, e;
        bit unstable = 0;
        m_ready = 0;
        rd_count = 0;
        for (int i = 1; i <= 12; i++) push(8'(i));
        exp_q.push_back({4'hF, 32'h04030201});
        exp_q.push_back({4'hF, 32'h08070605});
        exp_q.push_back({4'hF, 32'h0C0B0A09});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_valid && {m_keep, m_data} !== {4'hF, 32'h04030201}) unstable = 1;
            tick();
        end
        @(negedge clk);
        tests_run++;
        if (rd_count !== 8) begin tests_failed++; $display("FAIL bp_reads got=%0d exp=8", rd_count); end
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 32'h04030201 || unstable) begin
            tests_failed++;
            $display("FAIL bp_hold got valid=%b data=%h unstable=%b exp valid=1 data=04030201 unstable=0", m_valid, m_data, unstable);
        end
        tick();
        m_ready = 1;
        wait_words(3);
        for (int i = 0; i < 3; i++) begin
            w = got_q.size() != 0 ? got_q.pop_front() : 'x;
            e = exp_q.pop_front();
            tests_run++;
            if (w !== e) begin tests_failed++; $display("FAIL bp_word%0d got=%h exp=%h", i, w, e); end
        end
    endtask

    task automatic test_partial_flush();
        logic [35:0] w, e;
        push(8'hA1); push(8'hA2); push(8'hA3);
        exp_q.push_back({4'b0111, 32'h00A3A2A1});
        exp_q.push_back({4'hF, 32'hB3B2B1B0});
        for (int c = 0; c < 6; c++) tick();
        flush = 1;
        tick();
        flush = 0;
        push(8'hB0);
        @(negedge clk);
        tests_run++;
        if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL pflush_rd_blocked got=%b exp=0", fifo_rd_en); end
        tick();
        @(negedge clk);
        tests_run++;
        if (dut.flush_req !== 1'b0) begin tests_failed++; $display("FAIL pflush_req_clear got=%b exp=0", dut.flush_req); end
        push(8'hB1); push(8'hB2); push(8'hB3);
        wait_words(2);
        for (int i = 0; i < 2; i++) begin
            w = got_q.size() != 0 ? got_q.pop_front() : 'x;
            e = exp_q.pop_front();
            tests_run++;
            if (w !== e) begin tests_failed++; $display("FAIL pflush_word%0d got=%h exp=%h", i, w, e); end
        end
    endtask

    task automatic test_inflight_flush();
        logic [35:0] w, e;
        tick();
        push(8'hC1);
        tick();
        tick();
        push(8'hC2);
        flush = 1;
        exp_q.push_back({4'b0011, 32'h0000C2C1});
        @(negedge clk);
        tests_run++;
        if (fifo_rd_en !== 1'b1) begin tests_failed++; $display("FAIL inflight_rd_en got=%b exp=1", fifo_rd_en); end
        tick();
        flush = 0;
        wait_words(1);
        w = got_q.size() != 0 ? got_q.pop_front() : 'x;
        e = exp_q.pop_front();
        tests_run++;
        if (w !== e) begin tests_failed++; $display("FAIL inflight_word got=%h exp=%h", w, e); end
    endtask

    task automatic test_empty_flush();
        logic [35:0] w, e;
        bit saw_valid = 0;
        tick();
        flush = 1;
        tick();
        flush = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m_valid) saw_valid = 1;
            tick();
        end
        tests_run++;
        if (saw_valid || got_q.size() != 0) begin tests_failed++; $display("FAIL eflush_no_word got valid=%b words=%0d exp valid=0 words=0", saw_valid, got_q.size()); end
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        exp_q.push_back({4'hF, 32'hD4D3D2D1});
        wait_words(1);
        w = got_q.size() != 0 ? got_q.pop_front() : 'x;
        e = exp_q.pop_front();
        tests_run++;
        if (w !== e) begin tests_failed++; $display("FAIL eflush_word got=%h exp=%h", w, e); end
    endtask

    task automatic test_mid_reset();
        logic [35:0] w, e;
        m_ready = 0;
        for (int i = 1; i <= 6; i++) push(8'hE0 + 8'(i));
        for (int c = 0; c < 12; c++) tick();
        @(negedge clk);
        tests_run++;
        if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL mreset_pre_valid got=%b exp=1", m_valid); end
        tick();
        rst = 1;
        @(negedge clk);
        tests_run++;
        if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL mreset_rd_en got=%b exp=0", fifo_rd_en); end
        tick();
        rst = 0;
        m_ready = 1;
        @(negedge clk);
        tests_run++;
        w = {m_keep, m_data};
        if (m_valid !== 1'b0 || w !== 36'h0) begin tests_failed++; $display("FAIL mreset_outputs got valid=%b word=%h exp valid=0 word=0", m_valid, w); end
        push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
        exp_q.push_back({4'hF, 32'hF4F3F2F1});
        wait_words(1);
        w = got_q.size() != 0 ? got_q.pop_front() : 'x;
        e = exp_q.pop_front();
        tests_run++;
        if (w !== e) begin tests_failed++; $display("FAIL mreset_word got=%h exp=%h", w, e); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_partial_flush();
        test_inflight_flush();
        test_empty_flush();
        test_mid_reset();
        for (int c = 0; c < 10; c++) tick();
        tests_run++;
        if (got_q.size() != 0) begin tests_failed++; $display("FAIL extra_words got=%0d exp=0", got_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
